// File: rtl/pathfinding_pqueue.sv
// Sorted min-priority queue for the pathfinding frontier.
// Entries {vertex, prev_vertex, dist} are kept in ascending dist order in a
// shift-register array. Every operation is resolved in a single cycle.
// A pop or replace first shifts the array down to form a "base" array.
// The new entry is then inserted into that base array, after all entries whose
// key is less than or equal to its key, so equal keys leave in FIFO order.
module pathfinding_pqueue #(
   parameter int VERTEX_W = 16,
   parameter int DIST_W   = 16,
   parameter int DEPTH    = 16,
   parameter int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                op_en,
   input  logic [1:0]          opcode,
   input  logic [VERTEX_W-1:0] in_vertex,
   input  logic [VERTEX_W-1:0] in_prev_vertex,
   input  logic [DIST_W-1:0]   in_dist,
   output logic [CNT_W-1:0]    queue_length,
   output logic                empty,
   output logic                full,
   output logic [VERTEX_W-1:0] head_vertex,
   output logic [VERTEX_W-1:0] head_prev_vertex,
   output logic [DIST_W-1:0]   head_dist,
   output logic                pop_valid,
   output logic [VERTEX_W-1:0] pop_vertex,
   output logic [VERTEX_W-1:0] pop_prev_vertex,
   output logic [DIST_W-1:0]   pop_dist,
   output logic                discard_valid,
   output logic [VERTEX_W-1:0] discard_vertex,
   output logic [VERTEX_W-1:0] discard_prev_vertex,
   output logic [DIST_W-1:0]   discard_dist,
   output logic                underflow
);

   logic [VERTEX_W-1:0] r_vtx [DEPTH];
   logic [VERTEX_W-1:0] r_prv [DEPTH];
   logic [DIST_W-1:0]   r_dst [DEPTH];
   logic [CNT_W-1:0]    r_len;

   logic                r_pop_valid, r_discard_valid, r_underflow;
   logic [VERTEX_W-1:0] r_pop_vtx, r_pop_prv, r_dis_vtx, r_dis_prv;
   logic [DIST_W-1:0]   r_pop_dst, r_dis_dst;

   // Shifted-down copy, base array, insertion result and next state.
   logic [VERTEX_W-1:0] w_sh_vtx [DEPTH];
   logic [VERTEX_W-1:0] w_sh_prv [DEPTH];
   logic [DIST_W-1:0]   w_sh_dst [DEPTH];
   logic [VERTEX_W-1:0] w_b_vtx  [DEPTH];
   logic [VERTEX_W-1:0] w_b_prv  [DEPTH];
   logic [DIST_W-1:0]   w_b_dst  [DEPTH];
   logic [VERTEX_W-1:0] w_i_vtx  [DEPTH];
   logic [VERTEX_W-1:0] w_i_prv  [DEPTH];
   logic [DIST_W-1:0]   w_i_dst  [DEPTH];
   logic [VERTEX_W-1:0] w_n_vtx  [DEPTH];
   logic [VERTEX_W-1:0] w_n_prv  [DEPTH];
   logic [DIST_W-1:0]   w_n_dst  [DEPTH];
   logic [DEPTH-1:0]    w_le;

   logic             w_empty, w_full, w_is_push, w_is_pop, w_is_rep;
   logic             w_shift, w_ins;
   logic [CNT_W-1:0] w_base_len, w_len_next;

   assign w_empty   = (r_len == '0);
   assign w_full    = (r_len == CNT_W'(DEPTH));
   assign w_is_push = op_en && (opcode == 2'b01);
   assign w_is_pop  = op_en && (opcode == 2'b10);
   assign w_is_rep  = op_en && (opcode == 2'b11);
   // The head leaves the array on a pop or on a replace of a non-empty queue.
   assign w_shift   = (w_is_pop || w_is_rep) && !w_empty;
   // A replace on an empty queue degenerates to a plain push.
   assign w_ins     = w_is_push || w_is_rep;
   assign w_base_len = w_shift ? (r_len - CNT_W'(1)) : r_len;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_ent
         if (gi < DEPTH - 1) begin : g_mid
            assign w_sh_vtx[gi] = r_vtx[gi+1];
            assign w_sh_prv[gi] = r_prv[gi+1];
            assign w_sh_dst[gi] = r_dst[gi+1];
         end else begin : g_top
            assign w_sh_vtx[gi] = '0;
            assign w_sh_prv[gi] = '0;
            assign w_sh_dst[gi] = '0;
         end
         assign w_b_vtx[gi] = w_shift ? w_sh_vtx[gi] : r_vtx[gi];
         assign w_b_prv[gi] = w_shift ? w_sh_prv[gi] : r_prv[gi];
         assign w_b_dst[gi] = w_shift ? w_sh_dst[gi] : r_dst[gi];
         // Because the array is sorted, w_le is a prefix mask that marks the entries which stay in place.
         assign w_le[gi] = (CNT_W'(gi) < w_base_len) && (w_b_dst[gi] <= in_dist);
         if (gi == 0) begin : g_first
            assign w_i_vtx[gi] = w_le[0] ? w_b_vtx[0] : in_vertex;
            assign w_i_prv[gi] = w_le[0] ? w_b_prv[0] : in_prev_vertex;
            assign w_i_dst[gi] = w_le[0] ? w_b_dst[0] : in_dist;
         end else begin : g_rest
            assign w_i_vtx[gi] = w_le[gi] ? w_b_vtx[gi] : (w_le[gi-1] ? in_vertex      : w_b_vtx[gi-1]);
            assign w_i_prv[gi] = w_le[gi] ? w_b_prv[gi] : (w_le[gi-1] ? in_prev_vertex : w_b_prv[gi-1]);
            assign w_i_dst[gi] = w_le[gi] ? w_b_dst[gi] : (w_le[gi-1] ? in_dist        : w_b_dst[gi-1]);
         end
         assign w_n_vtx[gi] = w_ins ? w_i_vtx[gi] : w_b_vtx[gi];
         assign w_n_prv[gi] = w_ins ? w_i_prv[gi] : w_b_prv[gi];
         assign w_n_dst[gi] = w_ins ? w_i_dst[gi] : w_b_dst[gi];
      end
   endgenerate

   // Compute the next length. A full push evicts one entry, so the count does not change.
   always_comb begin
      w_len_next = r_len;
      if (w_shift && !w_ins)
         w_len_next = r_len - CNT_W'(1);
      else if (w_ins && !w_shift && !w_full)
         w_len_next = r_len + CNT_W'(1);
   end

   // Update the storage array and the length. Flush takes priority over any operation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_vtx[i] <= '0;
            r_prv[i] <= '0;
            r_dst[i] <= '0;
         end
         r_len <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_vtx[i] <= '0;
            r_prv[i] <= '0;
            r_dst[i] <= '0;
         end
         r_len <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            r_vtx[i] <= w_n_vtx[i];
            r_prv[i] <= w_n_prv[i];
            r_dst[i] <= w_n_dst[i];
         end
         r_len <= w_len_next;
      end
   end

   // Register the one-cycle result pulses. Their data fields hold between pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pop_valid     <= 1'b0;
         r_discard_valid <= 1'b0;
         r_underflow     <= 1'b0;
         r_pop_vtx <= '0;
         r_pop_prv <= '0;
         r_pop_dst <= '0;
         r_dis_vtx <= '0;
         r_dis_prv <= '0;
         r_dis_dst <= '0;
      end else begin
         r_pop_valid     <= !flush && w_shift;
         r_discard_valid <= !flush && w_is_push && w_full;
         r_underflow     <= !flush && w_is_pop && w_empty;
         if (!flush && w_shift) begin
            r_pop_vtx <= r_vtx[0];
            r_pop_prv <= r_prv[0];
            r_pop_dst <= r_dst[0];
         end
         if (!flush && w_is_push && w_full) begin
            // If the new key sorts after the last entry, the new entry itself is the one discarded.
            r_dis_vtx <= w_le[DEPTH-1] ? in_vertex      : r_vtx[DEPTH-1];
            r_dis_prv <= w_le[DEPTH-1] ? in_prev_vertex : r_prv[DEPTH-1];
            r_dis_dst <= w_le[DEPTH-1] ? in_dist        : r_dst[DEPTH-1];
         end
      end
   end

   assign queue_length        = r_len;
   assign empty               = w_empty;
   assign full                = w_full;
   assign head_vertex         = r_vtx[0];
   assign head_prev_vertex    = r_prv[0];
   assign head_dist           = r_dst[0];
   assign pop_valid           = r_pop_valid;
   assign pop_vertex          = r_pop_vtx;
   assign pop_prev_vertex     = r_pop_prv;
   assign pop_dist            = r_pop_dst;
   assign discard_valid       = r_discard_valid;
   assign discard_vertex      = r_dis_vtx;
   assign discard_prev_vertex = r_dis_prv;
   assign discard_dist        = r_dis_dst;
   assign underflow           = r_underflow;

endmodule

// File: tb/tb_pathfinding_pqueue.sv
// Testbench for pathfinding_pqueue (DEPTH=4).
// Directed scenarios are checked against literal values.
// Random traffic is checked every cycle against a queue-based model.
module tb_pathfinding_pqueue;

   localparam int VW = 16;
   localparam int DW = 16;
   localparam int DEPTH = 4;
   localparam int CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [VW-1:0] v;
      logic [VW-1:0] p;
      logic [DW-1:0] d;
   } ent_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          flush = 1'b0;
   logic          op_en = 1'b0;
   logic [1:0]    opcode = 2'b00;
   logic [VW-1:0] in_vertex = '0;
   logic [VW-1:0] in_prev_vertex = '0;
   logic [DW-1:0] in_dist = '0;
   logic [CW-1:0] queue_length;
   logic          empty, full, pop_valid, discard_valid, underflow;
   logic [VW-1:0] head_vertex, head_prev_vertex, pop_vertex, pop_prev_vertex;
   logic [VW-1:0] discard_vertex, discard_prev_vertex;
   logic [DW-1:0] head_dist, pop_dist, discard_dist;

   pathfinding_pqueue #(.VERTEX_W(VW), .DIST_W(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .flush(flush), .op_en(op_en), .opcode(opcode),
      .in_vertex(in_vertex), .in_prev_vertex(in_prev_vertex), .in_dist(in_dist),
      .queue_length(queue_length), .empty(empty), .full(full),
      .head_vertex(head_vertex), .head_prev_vertex(head_prev_vertex), .head_dist(head_dist),
      .pop_valid(pop_valid), .pop_vertex(pop_vertex), .pop_prev_vertex(pop_prev_vertex),
      .pop_dist(pop_dist), .discard_valid(discard_valid), .discard_vertex(discard_vertex),
      .discard_prev_vertex(discard_prev_vertex), .discard_dist(discard_dist),
      .underflow(underflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 0;

   // Behavioural model: a sorted queue plus the last values seen on the pulse ports.
   ent_t m_q[$];
   logic m_pv, m_dv, m_uf;
   ent_t m_pop, m_disc;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_q.delete();
      m_pv = 0; m_dv = 0; m_uf = 0;
      m_pop = '0; m_disc = '0;
   endtask

   task automatic m_insert(input ent_t e);
      int p = 0;
      foreach (m_q[i]) if (m_q[i].d <= e.d) p++;
      m_q.insert(p, e);
   endtask

   task automatic m_push(input ent_t e);
      if (m_q.size() < DEPTH) begin
         m_insert(e);
      end else begin
         m_dv = 1;
         if (e.d < m_q[DEPTH-1].d) begin
            m_disc = m_q[DEPTH-1];
            void'(m_q.pop_back());
            m_insert(e);
         end else begin
            m_disc = e;
         end
      end
   endtask

   task automatic m_apply(input logic fl, input logic en, input logic [1:0] opc, input ent_t e);
      m_pv = 0; m_dv = 0; m_uf = 0;
      if (fl) m_q.delete();
      else if (en) begin
         case (opc)
            2'b01: m_push(e);
            2'b10: if (m_q.size() == 0) m_uf = 1;
                   else begin m_pop = m_q.pop_front(); m_pv = 1; end
            2'b11: if (m_q.size() == 0) m_push(e);
                   else begin m_pop = m_q.pop_front(); m_pv = 1; m_insert(e); end
            default: ;
         endcase
      end
   endtask

   // Compare every DUT output with the model on the falling edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         ent_t h;
         h = (m_q.size() > 0) ? m_q[0] : '0;
         chk("len", 32'(queue_length), 32'(m_q.size()));
         chk("empty", 32'(empty), 32'(m_q.size() == 0));
         chk("full", 32'(full), 32'(m_q.size() == DEPTH));
         chk("head_vertex", 32'(head_vertex), 32'(h.v));
         chk("head_prev", 32'(head_prev_vertex), 32'(h.p));
         chk("head_dist", 32'(head_dist), 32'(h.d));
         chk("pop_valid", 32'(pop_valid), 32'(m_pv));
         chk("pop_vertex", 32'(pop_vertex), 32'(m_pop.v));
         chk("pop_prev", 32'(pop_prev_vertex), 32'(m_pop.p));
         chk("pop_dist", 32'(pop_dist), 32'(m_pop.d));
         chk("discard_valid", 32'(discard_valid), 32'(m_dv));
         chk("discard_vertex", 32'(discard_vertex), 32'(m_disc.v));
         chk("discard_prev", 32'(discard_prev_vertex), 32'(m_disc.p));
         chk("discard_dist", 32'(discard_dist), 32'(m_disc.d));
         chk("underflow", 32'(underflow), 32'(m_uf));
      end
   end

   task automatic step(input logic fl, input logic en, input logic [1:0] opc,
                       input logic [VW-1:0] v, input logic [VW-1:0] pv, input logic [DW-1:0] d);
      ent_t e;
      e.v = v; e.p = pv; e.d = d;
      flush = fl; op_en = en; opcode = opc;
      in_vertex = v; in_prev_vertex = pv; in_dist = d;
      @(posedge clk);
      m_apply(fl, en, opc, e);
      #1;
      flush = 1'b0; op_en = 1'b0; opcode = 2'b00;
      $display("op flush=%0d en=%0d opc=%0d v=%0d d=%0d -> len=%0d head_d=%0d pv=%0d dv=%0d uf=%0d",
               fl, en, opc, v, d, queue_length, head_dist, pop_valid, discard_valid, underflow);
   endtask

   task automatic push(input int v, input int d);
      step(1'b0, 1'b1, 2'b01, VW'(v), VW'(v + 100), DW'(d));
   endtask
   task automatic pop();
      step(1'b0, 1'b1, 2'b10, '0, '0, '0);
   endtask
   task automatic repl(input int v, input int d);
      step(1'b0, 1'b1, 2'b11, VW'(v), VW'(v + 100), DW'(d));
   endtask

   initial begin
      m_reset();
      @(negedge clk);
      chk("reset_len", 32'(queue_length), 0);
      chk("reset_empty", 32'(empty), 1);
      chk("reset_full", 32'(full), 0);
      chk("reset_head", 32'(head_dist), 0);
      @(negedge clk);
      reset = 1'b0;
      cmp_en = 1;

      // Sorted order.
      push(3, 30); push(1, 10); push(2, 20);
      chk("sort_head", 32'(head_dist), 10);
      chk("sort_len", 32'(queue_length), 3);
      pop(); chk("sort_pop1", 32'(pop_vertex), 1); chk("sort_pv1", 32'(pop_valid), 1);
      pop(); chk("sort_pop2", 32'(pop_vertex), 2);
      pop(); chk("sort_pop3", 32'(pop_vertex), 3); chk("sort_prev3", 32'(pop_prev_vertex), 103);
      chk("sort_empty", 32'(empty), 1);

      // Equal keys leave in FIFO order.
      push(5, 7); push(6, 7);
      pop(); chk("tie_pop1", 32'(pop_vertex), 5);
      pop(); chk("tie_pop2", 32'(pop_vertex), 6);

      // Behaviour when full.
      push(11, 1); push(12, 2); push(13, 3); push(14, 4);
      chk("full_flag", 32'(full), 1);
      push(20, 0);
      chk("evict_valid", 32'(discard_valid), 1);
      chk("evict_dist", 32'(discard_dist), 4);
      chk("evict_vertex", 32'(discard_vertex), 14);
      chk("evict_head", 32'(head_dist), 0);
      chk("evict_full", 32'(full), 1);
      push(21, 9);
      chk("reject_vertex", 32'(discard_vertex), 21);
      chk("reject_dist", 32'(discard_dist), 9);
      chk("reject_head", 32'(head_vertex), 20);
      chk("reject_len", 32'(queue_length), 4);
      step(1'b1, 1'b0, 2'b00, '0, '0, '0);

      // Replace.
      push(31, 2); push(32, 5);
      repl(33, 3);
      chk("rep_popd", 32'(pop_dist), 2);
      chk("rep_head", 32'(head_dist), 3);
      chk("rep_len", 32'(queue_length), 2);
      pop(); chk("rep_pop_a", 32'(pop_dist), 3);
      pop(); chk("rep_pop_b", 32'(pop_dist), 5);
      repl(34, 8);
      chk("rep_empty_len", 32'(queue_length), 1);
      chk("rep_empty_pv", 32'(pop_valid), 0);
      chk("rep_empty_uf", 32'(underflow), 0);
      pop();

      // Underflow, then flush with a simultaneous push.
      pop();
      chk("uf_pulse", 32'(underflow), 1);
      chk("uf_pv", 32'(pop_valid), 0);
      chk("uf_len", 32'(queue_length), 0);
      step(1'b0, 1'b0, 2'b00, '0, '0, '0);
      chk("uf_drop", 32'(underflow), 0);
      push(41, 4); push(42, 5); push(43, 6);
      step(1'b1, 1'b1, 2'b01, 16'd44, 16'd144, 16'd1);
      chk("flush_len", 32'(queue_length), 0);
      chk("flush_pv", 32'(pop_valid), 0);
      chk("flush_dv", 32'(discard_valid), 0);

      // Asynchronous reset between clock edges.
      push(51, 5); push(52, 6);
      #2;
      reset = 1'b1;
      m_reset();
      #1;
      chk("areset_len", 32'(queue_length), 0);
      chk("areset_head", 32'(head_dist), 0);
      chk("areset_empty", 32'(empty), 1);
      chk("areset_popd", 32'(pop_dist), 0);
      reset = 1'b0;
      push(53, 3);
      chk("areset_push", 32'(queue_length), 1);

      // Randomized traffic. Keys use a small range so that ties are frequent.
      for (int n = 0; n < 1500; n++) begin
         logic fl, en;
         logic [1:0] opc;
         fl  = ($urandom_range(0, 99) < 3);
         en  = ($urandom_range(0, 99) < 85);
         opc = 2'($urandom_range(0, 3));
         step(fl, en, opc, VW'($urandom_range(0, 255)), VW'($urandom_range(0, 255)),
              DW'($urandom_range(0, 15)));
      end

      @(negedge clk);
      cmp_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pathfinding_pqueue.md
Name: pathfinding_pqueue

Overview:
Parametrised, sorted min-priority queue for the Dijkstra/A* frontier in the pathfinding accelerator. Each entry holds {vertex, prev_vertex, dist}, ordered by ascending dist as a shift-register array. Supports push, pop, atomic replace (pop-min plus push) and flush, one operation per cycle. When the queue is full, the worst entry is evicted to a discard port rather than lost silently.

Parameters:
VERTEX_W, 16, width of vertex and prev_vertex fields
DIST_W, 16, width of dist key (unsigned compare)
DEPTH, 16, number of entries (>=2)
CNT_W, $clog2(DEPTH+1), width of queue_length

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
flush  input  1  synchronous clear, priority over op_en
op_en  input  1  operation strobe, sampled at posedge
opcode  input  2  00 nop, 01 push, 10 pop, 11 replace
in_vertex  input  VERTEX_W  vertex to insert
in_prev_vertex  input  VERTEX_W  predecessor of vertex
in_dist  input  DIST_W  key of inserted entry
queue_length  output  CNT_W  valid entry count
empty  output  1  queue_length==0
full  output  1  queue_length==DEPTH
head_vertex/head_prev_vertex/head_dist  output  VERTEX_W/VERTEX_W/DIST_W  entry[0], combinational from storage
pop_valid  output  1  one-cycle pulse, pop_* fields valid
pop_vertex/pop_prev_vertex/pop_dist  output  VERTEX_W/VERTEX_W/DIST_W  removed minimum
discard_valid  output  1  one-cycle pulse, discard_* fields valid
discard_vertex/discard_prev_vertex/discard_dist  output  VERTEX_W/VERTEX_W/DIST_W  entry dropped on full push
underflow  output  1  one-cycle pulse, pop on empty

Behaviour:
- Reset (async): all entries, queue_length, and every pulse and data output go to 0. empty=1, full=0.
- Storage: entry[0..len-1] sorted ascending by dist. Entries at or above len are held at 0.
- Insert position p = count of valid entries with dist <= in_dist. Ties are FIFO: a new entry goes after existing equal keys. Entries >= p shift up by one.
- Timing: an op is applied at the posedge where op_en=1. Storage, queue_length, empty, full and head_* update at that edge. Pulses and their fields are registered at that edge and high for exactly one cycle. Back-to-back ops every cycle are supported; there is no ready signal.
- Data fields hold their last value when their pulse is low.
- Push, not full: insert at p; len+1.
- Push, full, in_dist < entry[DEPTH-1].dist: insert at p. The old entry[DEPTH-1] is driven on discard_*, discard_valid=1. len unchanged.
- Push, full, in_dist >= entry[DEPTH-1].dist: storage unchanged. The input entry is driven on discard_*, discard_valid=1.
- Pop, non-empty: entry[0] is driven on pop_*, pop_valid=1. Entries shift down; entry[len-1] is cleared; len-1.
- Pop, empty: underflow=1, pop_valid=0, no state change.
- Replace, non-empty: entry[0] is driven on pop_*, pop_valid=1. The new entry is inserted among the remaining entries, with p computed over entry[1..len-1]. len unchanged. Never discards; valid when full.
- Replace, empty: behaves as push. pop_valid=0, underflow=0.
- Nop, or op_en=0: no state change; pulses 0.
- Flush=1: all entries and len go to 0 at the edge. op_en is ignored; pulses are 0 that cycle.
- Reset mid-stream: contents are lost immediately. The first edge after reset deassertion accepts ops normally.
- Compares are unsigned, full DIST_W. No arithmetic on keys, so no overflow is possible.

Test Plan:
- Reset, then push dist 30,10,20 (vertices 3,1,2) -> head_dist=10; pops return vertices 1,2,3 with pop_valid pulses; queue_length 3->0; empty=1.
- Push v5/d7 then v6/d7, then pop twice -> v5 first, then v6 (FIFO tie order).
- DEPTH=4: fill with d 1,2,3,4, then push d0 -> discard_valid with d4, head_dist=0, full=1. Then push d9 -> discard returns the d9 input, storage unchanged.
- Queue {d2,d5}: replace with d3 -> pop_dist=2, storage {d3,d5}, len=2. Replace on empty with d8 -> len=1, pop_valid=0.
- Pop on empty -> underflow pulse for 1 cycle, len stays 0. Flush with op_en=1 push on a 3-entry queue -> len=0, no pulses, push ignored.
- Assert reset asynchronously between edges while 2 entries are held -> outputs 0 before the next edge. A push right after deassertion -> len=1.
